// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU control and result-select codes.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J
   } imm_sel_e;

   // funct3 -> ALU op; sub only applies to R-type funct3=000 with funct7[5] set
   function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic sub);
      case (funct3)
         3'b000:  alu_decode = sub ? ALU_SUB : ALU_ADD;
         3'b010:  alu_decode = ALU_SLT;
         3'b110:  alu_decode = ALU_OR;
         3'b111:  alu_decode = ALU_AND;
         default: alu_decode = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through, one write port.
module register_file
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   logic [XLEN-1:0] regs [1:NREGS-1];
   logic            wr_ok;

   assign wr_ok = we && (wa != '0);

   // Synchronous clear on reset, otherwise write any register except x0
   always_ff @(posedge clk) begin
      if (rst) begin
         regs <= '{default: '0};
      end else if (wr_ok) begin
         regs[wa] <= wd;
      end
   end

   // Reads: x0 is zero, a same-cycle write to the read index is forwarded
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != '0) rd1 = (wr_ok && wa == ra1) ? wd : regs[ra1];
      if (ra2 != '0) rd2 = (wr_ok && wa == ra2) ? wd : regs[ra2];
   end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extend, ID/EX register.
module decode_cycle
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            JumpE,
   output logic            BranchE,
   output logic            ALUSrcE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            reg_write, mem_write, jump, branch, alu_src;
   result_src_e     result_src;
   alu_ctrl_e       alu_ctrl;
   imm_sel_e        imm_sel;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] rd1, rd2;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign Rs1D   = InstrD[19:15];
   assign Rs2D   = InstrD[24:20];

   register_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_rf (
      .clk (clk),
      .rst (rst),
      .we  (RegWriteW),
      .wa  (RdW),
      .wd  (ResultW),
      .ra1 (Rs1D),
      .ra2 (Rs2D),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   // Main control decode by opcode; unknown opcodes fall through as a NOP
   always_comb begin
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      jump       = 1'b0;
      branch     = 1'b0;
      alu_src    = 1'b0;
      result_src = RES_ALU;
      alu_ctrl   = ALU_ADD;
      imm_sel    = IMM_NONE;
      case (opcode)
         OP_LOAD: begin
            reg_write  = 1'b1;
            alu_src    = 1'b1;
            result_src = RES_MEM;
            imm_sel    = IMM_I;
         end
         OP_STORE: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            imm_sel   = IMM_S;
         end
         OP_RTYPE: begin
            reg_write = 1'b1;
            alu_ctrl  = alu_decode(funct3, InstrD[30]);
         end
         OP_ITYPE: begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_ctrl  = alu_decode(funct3, 1'b0);
            imm_sel   = IMM_I;
         end
         OP_BRANCH: begin
            branch   = 1'b1;
            alu_ctrl = ALU_SUB;
            imm_sel  = IMM_B;
         end
         OP_JAL: begin
            reg_write  = 1'b1;
            jump       = 1'b1;
            result_src = RES_PC4;
            imm_sel    = IMM_J;
         end
         default: ;
      endcase
   end

   // Sign-extended immediate for the selected instruction format
   always_comb begin
      imm_ext = '0;
      case (imm_sel)
         IMM_I: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
         IMM_S: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B: imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         IMM_J: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
         default: imm_ext = '0;
      endcase
   end

   // ID/EX register: reset and flush both load a fully zeroed bubble
   always_ff @(posedge clk) begin
      if (rst || FlushE) begin
         RegWriteE   <= 1'b0;
         MemWriteE   <= 1'b0;
         JumpE       <= 1'b0;
         BranchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ResultSrcE  <= '0;
         ALUControlE <= '0;
         RD1E        <= '0;
         RD2E        <= '0;
         ImmExtE     <= '0;
         PCE         <= '0;
         PCPlus4E    <= '0;
         Rs1E        <= '0;
         Rs2E        <= '0;
         RdE         <= '0;
      end else begin
         RegWriteE   <= reg_write;
         MemWriteE   <= mem_write;
         JumpE       <= jump;
         BranchE     <= branch;
         ALUSrcE     <= alu_src;
         ResultSrcE  <= result_src;
         ALUControlE <= alu_ctrl;
         RD1E        <= rd1;
         RD2E        <= rd2;
         ImmExtE     <= imm_ext;
         PCE         <= PCD;
         PCPlus4E    <= PCPlus4D;
         Rs1E        <= Rs1D;
         Rs2E        <= Rs2D;
         RdE         <= InstrD[11:7];
      end
   end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Decode stage of the 5-stage RV32I pipeline.
- Consumes the IF/ID outputs of the fetch stage (instruction, PC, PC+4).
- Decodes control, reads the 32x32 register file and sign-extends the immediate.
- Registers all of it into the ID/EX pipeline register for the execute stage; the register file write port is fed from writeback.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register file depth; x0 is hardwired to zero.

Ports:
- clk  in  1  stage clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- InstrD  in  32  instruction from IF/ID.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PC+4 of InstrD.
- FlushE  in  1  high converts the ID/EX load into a bubble (driven by PCSrcE or the hazard unit).
- RegWriteW  in  1  writeback enable.
- RdW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- Rs1D, Rs2D  out  5 each  combinational source fields (InstrD[19:15], InstrD[24:20]), for the hazard unit.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control.
- ResultSrcE  out  2  registered result select: 00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  3  registered ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data.
- Rs1E, Rs2E, RdE  out  5 each  registered register indices.

Behaviour:
- Reset: at a posedge with rst=1, all E outputs become 0 and all 31 writable registers become 0. rst has priority over FlushE and RegWriteW.
- Latency: 1 cycle. Values presented in cycle n appear on the E outputs after posedge n.
- Decode by opcode; decode is combinational, and the outputs are registered at the ID/EX register.
  - 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=01, ALU=add, I-imm.
  - 0100011 sw: MemWrite=1, ALUSrc=1, ALU=add, S-imm.
  - 0110011 R-type: RegWrite=1, ALUSrc=0; funct3/funct7[5] select: add 000/0, sub 000/1, slt 010, or 110, and 111.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1; same funct3 map, always add for 000 (funct7 ignored).
  - 1100011 beq: Branch=1, ALU=sub, B-imm.
  - 1101111 jal: RegWrite=1, Jump=1, ResultSrc=10, J-imm.
  - Any other opcode: all control 0, ImmExt=0. This is a NOP, not an error.
- Immediates are sign-extended from instr[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Register file:
  - Write at posedge when RegWriteW=1, RdW!=0 and rst=0.
  - Writes to x0 are ignored; a read of x0 always returns 0.
  - Read is combinational with write-through: if RegWriteW=1, RdW!=0 and RdW equals the read index, the read returns ResultW in the same cycle.
- Flush: FlushE=1 at a posedge (rst=0) loads RegWriteE, MemWriteE, JumpE, BranchE = 0. All other E fields are also cleared to 0, so a bubble is deterministic. A register file write in the same cycle still occurs.
- No stall input. The ID/EX register loads every non-reset cycle.
- Reset mid-stream: pending ID/EX contents are discarded and the register file is cleared. The first post-reset instruction decodes normally.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
  - ALU control codes;
  - ResultSrc codes.
- Sub-module register_file: 2 read / 1 write ports, x0 hardwired, write-through bypass, synchronous clear on rst.
- Decoder and immediate-extend stay inline as combinational logic.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 with InstrD=0 → all E outputs 0; a read of x5 returns 0.
- Writeback + bypass: RegWriteW=1, RdW=5, ResultW=0x0000_00AA while InstrD=add x6,x5,x5 (0x00528333) → next cycle RD1E=RD2E=0xAA, RdE=6, RegWriteE=1, ALUControlE=000.
- x0 protection: write RdW=0 with ResultW=0xFFFF_FFFF, then decode addi x1,x0,-1 (0xFFF00093) → RD1E=0, ImmExtE=0xFFFF_FFFF, ALUSrcE=1.
- Immediates:
  - sw x2,-4(x3) (0xFE21AE23) → MemWriteE=1, ImmExtE=0xFFFF_FFFC.
  - beq with 0xFE000EE3 → BranchE=1, ALUControlE=001, ImmExtE=0xFFFF_FFFC.
  - jal x1,+8 (0x008000EF) → JumpE=1, ResultSrcE=10, ImmExtE=8.
- Flush: FlushE=1 with InstrD=lw x7,0(x2) (0x00012383) → RegWriteE=MemWriteE=JumpE=BranchE=0 and all E fields 0. The following cycle without flush decodes the same lw normally with ResultSrcE=01.
- Unknown opcode 0x0000007F → all control 0, ImmExtE=0.
